cam_tx_arbiter: RTL and testbench

Schedules the single outgoing byte channel (serial transmitter) between two requesters: the camera capture stream, which emits unthrottled byte strobes, and a status/command source with a valid/ready handshake. Camera bytes are absorbed in a small FIFO so they are never lost while the transmitter is busy. A bounded-burst priority scheme prevents status starvation. The block sits between the camera capture block and the UART transmitter, in the pixel-clock domain.

---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_byte_fifo.sv | 57 +++++
 rtl/cam_tx_arbiter.sv | 113 +++++++++++
 tb/tb_cam_tx_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera/status transmit arbiter: grant encoding,
// byte width and the width helper used for FIFO pointers and occupancy.
package cam_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CAM  = 2'd1,
      GNT_STAT = 2'd2
   } gnt_e;

   // Ceiling log2; exact for the power-of-two FIFO depths this block accepts.
   function automatic int log2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/cam_byte_fifo.sv
// Synchronous FIFO absorbing camera bytes; an extra occupancy bit separates
// full from empty while the pointers wrap modulo DEPTH.
module cam_byte_fifo
   import cam_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = BYTE_W
) (
   input  logic                     PCLK,
   input  logic                     RST,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [log2(DEPTH):0]     o_level
);

   localparam int AW = log2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_wr;
   logic             w_rd;

   assign o_full  = (r_level == (AW + 1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign w_wr    = i_push & ~o_full;
   assign w_rd    = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_level = r_level;

   // NOTE: storage is not reset; pointers and level decide which entries are live.
   always_ff @(posedge PCLK) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge PCLK or posedge RST) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/cam_tx_arbiter.sv
// Shares the transmit byte channel between the buffered camera stream and a
// valid/ready status source; camera bursts are capped while status waits.
module cam_tx_arbiter
   import cam_pkg::*;
#(
   parameter int pFifoDepth = 16,
   parameter int pBurst     = 8
) (
   input  logic                        PCLK,
   input  logic                        RST,
   input  logic [BYTE_W-1:0]           CDATA,
   input  logic                        CREQ,
   input  logic [BYTE_W-1:0]           SDATA,
   input  logic                        SVALID,
   output logic                        SREADY,
   output logic [BYTE_W-1:0]           TDATA,
   output logic                        TVALID,
   input  logic                        TREADY,
   input  logic                        CLR_OVF,
   output logic                        OVF,
   output logic [log2(pFifoDepth):0]   LEVEL
);

   logic [BYTE_W-1:0] r_tdata;
   logic              r_tvalid;
   logic              r_ovf;
   logic [7:0]        r_burst;
   gnt_e              r_gnt;
   gnt_e              w_gnt_nxt;
   logic              w_slot_free;
   logic              w_cam_ok;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [BYTE_W-1:0] w_fifo_data;

   cam_byte_fifo #(
      .DEPTH (pFifoDepth),
      .WIDTH (BYTE_W)
   ) u_fifo (
      .PCLK    (PCLK),
      .RST     (RST),
      .i_push  (CREQ),
      .i_data  (CDATA),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (LEVEL)
   );

   assign w_slot_free = ~r_tvalid | TREADY;
   assign w_cam_ok    = ~w_empty & (~SVALID | (r_burst < 8'(pBurst)));

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      w_gnt_nxt = r_gnt;
      SREADY    = 1'b0;
      w_pop     = 1'b0;
      if (w_slot_free) begin
         if (w_cam_ok) begin
            w_gnt_nxt = GNT_CAM;
            w_pop     = 1'b1;
         end else if (SVALID) begin
            w_gnt_nxt = GNT_STAT;
            SREADY    = 1'b1;
         end else begin
            w_gnt_nxt = GNT_NONE;
         end
      end
   end

   always_ff @(posedge PCLK or posedge RST) begin
      if (RST) r_gnt <= GNT_NONE;
      else     r_gnt <= w_gnt_nxt;
   end

   always_ff @(posedge PCLK or posedge RST) begin
      if (RST) begin
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_burst  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_slot_free) begin
            case (w_gnt_nxt)
               GNT_CAM: begin
                  r_tdata  <= w_fifo_data;
                  r_tvalid <= 1'b1;
                  if (r_burst != 8'hFF) r_burst <= r_burst + 8'd1;
               end
               GNT_STAT: begin
                  r_tdata  <= SDATA;
                  r_tvalid <= 1'b1;
                  r_burst  <= '0;
               end
               default: begin
                  r_tvalid <= 1'b0;
                  r_burst  <= '0;
               end
            endcase
         end
         // A drop outranks a clear in the same cycle.
         if (CREQ & w_full)  r_ovf <= 1'b1;
         else if (CLR_OVF)   r_ovf <= 1'b0;
      end
   end

   assign TDATA  = r_tdata;
   assign TVALID = r_tvalid;
   assign OVF    = r_ovf;

endmodule

// File: tb/tb_cam_tx_arbiter.sv
// Scoreboard bench for cam_tx_arbiter: a queue-based reference model predicts
// each transmitted byte; a negedge monitor compares whatever the DUT presents.
module tb_cam_tx_arbiter;
   import cam_pkg::*;

   localparam int DEPTH = 16;
   localparam int BURST = 8;
   localparam int LW    = log2(DEPTH) + 1;

   logic          PCLK = 1'b0;
   logic          RST;
   logic [7:0]    CDATA;
   logic          CREQ;
   logic [7:0]    SDATA;
   logic          SVALID;
   logic          SREADY;
   logic [7:0]    TDATA;
   logic          TVALID;
   logic          TREADY;
   logic          CLR_OVF;
   logic          OVF;
   logic [LW-1:0] LEVEL;

   cam_tx_arbiter #(.pFifoDepth(DEPTH), .pBurst(BURST)) dut (
      .PCLK    (PCLK),
      .RST     (RST),
      .CDATA   (CDATA),
      .CREQ    (CREQ),
      .SDATA   (SDATA),
      .SVALID  (SVALID),
      .SREADY  (SREADY),
      .TDATA   (TDATA),
      .TVALID  (TVALID),
      .TREADY  (TREADY),
      .CLR_OVF (CLR_OVF),
      .OVF     (OVF),
      .LEVEL   (LEVEL)
   );

   always #5 PCLK = ~PCLK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: camera FIFO as a queue, output slot, burst count, sticky flag.
   byte unsigned m_fifo[$];
   byte unsigned exp_q[$];
   byte unsigned stat_q[$];
   byte unsigned tx_log[$];
   bit           m_tvalid;
   byte unsigned m_tdata;
   int           m_burst;
   bit           m_ovf;
   int           n_accept;

   task automatic model_reset();
      m_fifo.delete();
      exp_q.delete();
      m_tvalid = 1'b0;
      m_tdata  = 8'h00;
      m_burst  = 0;
      m_ovf    = 1'b0;
   endtask

   always @(posedge PCLK) begin : model
      bit free;
      bit full;
      if (!RST) begin
         free = !m_tvalid || TREADY;
         full = (m_fifo.size() == DEPTH);
         if (free) begin
            if (m_fifo.size() > 0 && (!SVALID || m_burst < BURST)) begin
               m_tdata  = m_fifo.pop_front();
               m_tvalid = 1'b1;
               if (m_burst < 255) m_burst++;
               exp_q.push_back(m_tdata);
            end else if (SVALID) begin
               m_tdata  = SDATA;
               m_tvalid = 1'b1;
               m_burst  = 0;
               exp_q.push_back(SDATA);
            end else begin
               m_tvalid = 1'b0;
               m_burst  = 0;
            end
         end
         if (CREQ && full)  m_ovf = 1'b1;
         else if (CLR_OVF)  m_ovf = 1'b0;
         if (CREQ && !full) m_fifo.push_back(CDATA);
      end
   end

   // Monitor: per-cycle flags plus scoreboard pop on every accepted output byte.
   always @(negedge PCLK) begin : monitor
      bit exp_sr;
      if (!RST) begin
         exp_sr = (!m_tvalid || TREADY) && SVALID &&
                  !(m_fifo.size() > 0 && (!SVALID || m_burst < BURST));
         check("sready", SREADY, exp_sr);
         check("tvalid", TVALID, m_tvalid);
         check("level", LEVEL, m_fifo.size());
         check("ovf", OVF, m_ovf);
         if (m_tvalid) check("tdata_hold", TDATA, m_tdata);
         if (TVALID && TREADY) begin
            tx_log.push_back(TDATA);
            if (exp_q.size() == 0) check("sb_unexpected_byte", TDATA, 32'hFFFF_FFFF);
            else                   check("sb_tdata", TDATA, exp_q.pop_front());
         end
      end
   end

   // Status source: holds SDATA until accepted, then offers the next queued byte.
   initial begin : status_driver
      bit acc;
      SVALID = 1'b0;
      SDATA  = 8'h00;
      forever begin
         @(negedge PCLK);
         acc = SVALID && SREADY && !RST;
         @(posedge PCLK);
         #2;
         if (acc) begin
            void'(stat_q.pop_front());
            n_accept++;
         end
         SVALID = (stat_q.size() > 0);
         SDATA  = SVALID ? stat_q[0] : 8'($urandom);
      end
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic drain(input int n);
      CREQ   = 1'b0;
      TREADY = 1'b1;
      repeat (n) tick();
   endtask

   initial begin : stimulus
      int idx;
      RST = 1'b1; CREQ = 1'b0; CDATA = 8'h00; TREADY = 1'b0; CLR_OVF = 1'b0;
      n_accept = 0;
      model_reset();
      repeat (3) tick();
      check("rst_tvalid", TVALID, 0);
      check("rst_tdata",  TDATA, 0);
      check("rst_sready", SREADY, 0);
      check("rst_level",  LEVEL, 0);
      check("rst_ovf",    OVF, 0);
      RST = 1'b0;

      // Single camera byte: visible two edges after the strobe, for one cycle.
      TREADY = 1'b1;
      tick();
      CREQ = 1'b1; CDATA = 8'h2B;
      tick();
      CREQ = 1'b0;
      check("cam_lat_n_tvalid", TVALID, 0);
      check("cam_lat_n_level", LEVEL, 1);
      tick();
      check("cam_lat_tvalid", TVALID, 1);
      check("cam_lat_tdata", TDATA, 8'h2B);
      check("cam_lat_level", LEVEL, 0);
      tick();
      check("cam_lat_one_cycle", TVALID, 0);

      // Fill to full with the transmitter stalled, then overflow and clear.
      TREADY = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         CREQ = 1'b1; CDATA = 8'(i);
         tick();
      end
      CREQ = 1'b0;
      check("fill_level", LEVEL, 16);
      check("fill_ovf", OVF, 0);
      check("fill_head", TDATA, 8'h00);
      CREQ = 1'b1; CDATA = 8'h11;
      tick();
      CREQ = 1'b0;
      check("ovf_set", OVF, 1);
      CLR_OVF = 1'b1;
      tick();
      CLR_OVF = 1'b0;
      check("ovf_clr", OVF, 0);
      drain(24);

      // Burst cap: status waits for at most BURST camera bytes.
      TREADY = 1'b0;
      for (int i = 0; i < 16; i++) begin
         CREQ = 1'b1; CDATA = 8'(8'h40 + i);
         tick();
      end
      tx_log.delete();
      n_accept = 0;
      stat_q.push_back(8'hA5);
      TREADY = 1'b1;
      for (int i = 16; i < 21; i++) begin
         CREQ = 1'b1; CDATA = 8'(8'h40 + i);
         tick();
      end
      drain(30);
      idx = -1;
      foreach (tx_log[i]) if (tx_log[i] == 8'hA5 && idx < 0) idx = i;
      check("burst_len", idx, BURST);
      check("burst_resume", (idx >= 0 && idx + 1 < tx_log.size()) ? 32'(tx_log[idx+1]) : 32'hFFFF, 8'h48);
      check("burst_accepts", n_accept, 1);
      check("burst_total", tx_log.size(), 22);

      // Status with empty FIFO, held across a stalled transmitter.
      tx_log.delete();
      n_accept = 0;
      stat_q.push_back(8'h3C);
      tick();
      TREADY = 1'b0;
      check("stat_tvalid", TVALID, 1);
      check("stat_tdata", TDATA, 8'h3C);
      tick();
      check("stat_hold_tvalid", TVALID, 1);
      check("stat_hold_tdata", TDATA, 8'h3C);
      TREADY = 1'b1;
      repeat (3) tick();
      check("stat_accepts", n_accept, 1);
      check("stat_sent_once", tx_log.size(), 1);

      // Concurrent push and pop at level 5, across pointer wrap.
      TREADY = 1'b0;
      for (int i = 0; i < 6; i++) begin
         CREQ = 1'b1; CDATA = 8'($urandom);
         tick();
      end
      check("lvl5_start", LEVEL, 5);
      TREADY = 1'b1;
      for (int i = 0; i < 40; i++) begin
         CREQ = 1'b1; CDATA = 8'($urandom);
         tick();
         check("lvl5_steady", LEVEL, 5);
      end
      drain(12);

      // Randomised phases with varying load, stalls, status traffic and clears.
      for (int ph = 0; ph < 16; ph++) begin
         int p_creq;
         int p_rdy;
         p_creq = $urandom_range(20, 90);
         p_rdy  = $urandom_range(20, 100);
         for (int c = 0; c < 100; c++) begin
            CREQ    = ($urandom_range(99) < p_creq);
            CDATA   = 8'($urandom);
            TREADY  = ($urandom_range(99) < p_rdy);
            CLR_OVF = ($urandom_range(99) < 3);
            if (stat_q.size() < 2 && $urandom_range(99) < 10) stat_q.push_back(8'($urandom));
            tick();
         end
      end
      CLR_OVF = 1'b0;
      drain(40);
      check("rand_stat_done", stat_q.size(), 0);

      // Reset in the middle of a held transfer with data buffered and OVF set.
      TREADY = 1'b0;
      for (int i = 0; i < 18; i++) begin
         CREQ = 1'b1; CDATA = 8'(8'h60 + i);
         tick();
      end
      CREQ = 1'b0;
      TREADY = 1'b1;
      repeat (9) tick();
      TREADY = 1'b0;
      check("pre_rst_level", LEVEL, 7);
      check("pre_rst_tvalid", TVALID, 1);
      check("pre_rst_ovf", OVF, 1);
      #2;
      RST = 1'b1;
      model_reset();
      #1;
      check("async_rst_tvalid", TVALID, 0);
      check("async_rst_level", LEVEL, 0);
      check("async_rst_ovf", OVF, 0);
      check("async_rst_tdata", TDATA, 0);
      tick();
      RST = 1'b0;
      TREADY = 1'b1;
      tx_log.delete();
      CREQ = 1'b1; CDATA = 8'h77;
      tick();
      CDATA = 8'h78;
      tick();
      drain(5);
      check("post_rst_first", (tx_log.size() > 0) ? 32'(tx_log[0]) : 32'hFFFF, 8'h77);
      check("post_rst_count", tx_log.size(), 2);

      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
